elevator_call_register: RTL

Input stage between the three active-low floor call buttons and the elevator controller FSM. Synchronises and optionally debounces each raw button, turns each press into a one-cycle call event, and holds a per-floor pending-call bit until the controller reports the floor served. The pending bits drive the floor call LEDs directly.

---
 rtl/elevator_call_register.sv | 111 +++++++++++
 1 files changed

// File: rtl/elevator_call_register.sv
// Floor call input stage: sync, optional debounce (CALL_DEBOUNCE_EN),
// press-edge detect and per-floor pending-call latch for the LEDs.
module elevator_call_register #(
    parameter int N_FLOORS        = 3,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FW              = $clog2(N_FLOORS)
) (
    input  logic                clk_50,
    input  logic                rst,
    input  logic [N_FLOORS-1:0] button_n,
    input  logic                serve_en,
    input  logic [FW-1:0]       serve_floor,
    output logic [N_FLOORS-1:0] call_pending,
    output logic [N_FLOORS-1:0] new_call,
    output logic                pending_any,
    output logic [FW:0]         pending_count
);

    localparam int CW = FW + 1;

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255) begin : g_bad_db
        $error("DEBOUNCE_CYCLES must be 2..255");
    end

    logic [N_FLOORS-1:0] s1_q;
    logic [N_FLOORS-1:0] s2_q;
    logic [N_FLOORS-1:0] filt;
    logic [N_FLOORS-1:0] filt_q;
    logic [N_FLOORS-1:0] armed_q;
    logic                primed_q;
    logic [N_FLOORS-1:0] press;
    logic [N_FLOORS-1:0] new_call_q;
    logic [N_FLOORS-1:0] pending_q;
    logic [N_FLOORS-1:0] pending_d;

`ifdef CALL_DEBOUNCE_EN
    localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic [N_FLOORS-1:0] filt_db_q;
    logic [7:0]          cnt_q [N_FLOORS];

    always_ff @(posedge clk_50) begin
        if (rst) begin
            filt_db_q <= '1;
            for (int i = 0; i < N_FLOORS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_FLOORS; i++) begin
                if (s2_q[i] == filt_db_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == DB_LAST) begin
                    filt_db_q[i] <= s2_q[i];
                    cnt_q[i]     <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 8'd1;
                end
            end
        end
    end

    assign filt = filt_db_q;
`else
    assign filt = s2_q;
`endif

    // A floor is armed only once its button has been seen released after
    // reset, so a button held through reset cannot fake a press.
    assign press = filt_q & ~filt & armed_q;

    always_comb begin
        pending_d = pending_q | press;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (serve_en && serve_floor == FW'(i)) begin
                pending_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_50) begin
        if (rst) begin
            s1_q       <= '1;
            s2_q       <= '1;
            filt_q     <= '1;
            primed_q   <= 1'b0;
            armed_q    <= '0;
            new_call_q <= '0;
            pending_q  <= '0;
        end else begin
            s1_q       <= button_n;
            s2_q       <= s1_q;
            filt_q     <= filt;
            primed_q   <= 1'b1;
            armed_q    <= armed_q | ({N_FLOORS{primed_q}} & s1_q);
            new_call_q <= press;
            pending_q  <= pending_d;
        end
    end

    always_comb begin
        pending_count = '0;
        for (int i = 0; i < N_FLOORS; i++) begin
            pending_count = pending_count + CW'(pending_q[i]);
        end
    end

    assign call_pending = pending_q;
    assign new_call     = new_call_q;
    assign pending_any  = |pending_q;

endmodule
